// File: rtl/bmem_line_responder_if.sv
// Signal bundle for the 64-bit burst memory link between the cache-line adapter and its memory.
// The master drives requests and write beats; the slave returns ready, tagged read beats and the error flag.
// The same names are used on both sides so the link can be wired straight through.
interface bmem_line_responder_if;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;
    logic        proto_err;

    modport master (
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, proto_err
    );

    modport slave (
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, proto_err
    );
endinterface

// File: rtl/bmem_line_responder.sv
// Line-addressed memory endpoint: accepts 4-beat write bursts and queued line reads, returns 4-beat read bursts in order.
// Latency: first read beat is registered LATENCY edges after the read is accepted, later only if the channel is busy.
// Backpressure: bmem_ready drops while the read queue is full (never inside a write burst); requests seen while not ready are dropped and flagged.
module bmem_line_responder #(
    parameter int LATENCY  = 8,
    parameter int QDEPTH   = 4,
    parameter int IDX_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    bmem_line_responder_if.slave  bus
);
    localparam int PTR_BITS = $clog2(QDEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam int LINES    = 1 << IDX_BITS;
    localparam logic [15:0]         ELIG_AGE = 16'(LATENCY - 1);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(QDEPTH);
    localparam logic [CNT_BITS-1:0] TWO_CNT  = CNT_BITS'(2);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Backing store, one 64-bit word per {line, beat}; deliberately never reset
    logic [63:0]          r_mem [LINES*4];
    // Read request queue: line address (addr[31:5]) and acceptance timestamp
    logic [26:0]          r_q_addr  [QDEPTH];
    logic [15:0]          r_q_stamp [QDEPTH];

    logic [PTR_BITS-1:0]  r_wr_ptr;
    logic [PTR_BITS-1:0]  r_rd_ptr;
    logic [CNT_BITS-1:0]  r_count;
    logic [15:0]          r_ts;
    logic [1:0]           r_wbeat;
    logic [IDX_BITS-1:0]  r_wline;
    logic [0:0]           r_state;
    logic [1:0]           r_rbeat;
    logic                 r_ready;
    logic                 r_rvalid;
    logic [31:0]          r_raddr;
    logic [63:0]          r_rdata;
    logic                 r_err;

    logic                 w_in_wburst;
    logic                 w_wr_first;
    logic                 w_wr_cont;
    logic                 w_wr_abort;
    logic                 w_wr_err;
    logic                 w_we;
    logic [IDX_BITS+1:0]  w_wr_idx;
    logic [1:0]           w_wbeat_nxt;
    logic                 w_full;
    logic                 w_push;
    logic                 w_rd_drop;
    logic                 w_pop;
    logic [CNT_BITS-1:0]  w_count_nxt;
    logic [PTR_BITS-1:0]  w_next_ptr;
    logic [15:0]          w_head_age;
    logic [15:0]          w_next_age;
    logic                 w_head_elig;
    logic                 w_next_elig;
    logic [IDX_BITS+1:0]  w_rd_idx;
    logic                 w_unused;

    // Low address bits only select bytes inside a line, which this endpoint never does
    assign w_unused = &{1'b0, bus.bmem_addr[4:0]};

    // Write side: beat 0 needs ready, beats 1..3 are owed on the following edges
    assign w_in_wburst = (r_wbeat != 2'd0);
    assign w_wr_first  = bus.bmem_write & r_ready & ~w_in_wburst;
    assign w_wr_cont   = bus.bmem_write & w_in_wburst;
    assign w_wr_abort  = ~bus.bmem_write & w_in_wburst;
    assign w_wr_err    = bus.bmem_write & ~r_ready & ~w_in_wburst;
    assign w_we        = w_wr_first | w_wr_cont;
    assign w_wr_idx    = w_wr_first ? {bus.bmem_addr[5+IDX_BITS-1:5], 2'b00} : {r_wline, r_wbeat};

    // Read queue: ready may be held high through a write burst, so fullness is re-checked here
    assign w_full      = (r_count == FULL_CNT);
    assign w_push      = bus.bmem_read & r_ready & ~w_full;
    assign w_rd_drop   = bus.bmem_read & ~w_push;
    assign w_pop       = (r_state == ST_BURST) && (r_rbeat == 2'd3);
    assign w_count_nxt = r_count + CNT_BITS'(w_push) - CNT_BITS'(w_pop);
    assign w_next_ptr  = r_rd_ptr + PTR_BITS'(1);

    // Ages wrap modulo 2^16 along with the timestamp
    assign w_head_age  = r_ts - r_q_stamp[r_rd_ptr];
    assign w_next_age  = r_ts - r_q_stamp[w_next_ptr];
    assign w_head_elig = (r_count != '0) && (w_head_age >= ELIG_AGE);
    assign w_next_elig = (r_count >= TWO_CNT) && (w_next_age >= ELIG_AGE);
    assign w_rd_idx    = {r_q_addr[r_rd_ptr][IDX_BITS-1:0], r_rbeat};

    // Next write beat counter: advances on each accepted beat, falls back to 0 on a missing beat
    always_comb begin
        w_wbeat_nxt = r_wbeat;
        if (w_wr_first)
            w_wbeat_nxt = 2'd1;
        else if (w_wr_cont)
            w_wbeat_nxt = r_wbeat + 2'd1;
        else if (w_wr_abort)
            w_wbeat_nxt = 2'd0;
    end

    // Commit write beats into the backing store
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_wr_idx] <= bus.bmem_wdata;
    end

    // Capture queued read requests with their acceptance timestamp
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr]  <= bus.bmem_addr[31:5];
            r_q_stamp[r_wr_ptr] <= r_ts;
        end
    end

    // Free-running timestamp
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ts <= '0;
        else
            r_ts <= r_ts + 16'd1;
    end

    // Write burst beat counter and latched line index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbeat <= '0;
            r_wline <= '0;
        end else begin
            r_wbeat <= w_wbeat_nxt;
            if (w_wr_first)
                r_wline <= bus.bmem_addr[5+IDX_BITS-1:5];
        end
    end

    // Queue pointers, occupancy and the registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            if (w_pop)
                r_rd_ptr <= w_next_ptr;
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != FULL_CNT) || (w_wbeat_nxt != 2'd0);
        end
    end

    // Response FSM: wait for the head to age, then register four beats, chaining eligible bursts back to back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rbeat  <= '0;
            r_rvalid <= 1'b0;
            r_raddr  <= '0;
            r_rdata  <= '0;
        end else if (r_state == ST_IDLE) begin
            r_rvalid <= 1'b0;
            r_rbeat  <= '0;
            if (w_head_elig)
                r_state <= ST_BURST;
        end else begin
            r_rvalid <= 1'b1;
            r_raddr  <= {r_q_addr[r_rd_ptr], 5'b0};
            r_rdata  <= r_mem[w_rd_idx];
            r_rbeat  <= r_rbeat + 2'd1;
            if (r_rbeat == 2'd3 && !w_next_elig)
                r_state <= ST_IDLE;
        end
    end

    // Sticky protocol error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_rd_drop || w_wr_err || w_wr_abort)
            r_err <= 1'b1;
    end

    assign bus.bmem_ready  = r_ready;
    assign bus.bmem_rvalid = r_rvalid;
    assign bus.bmem_raddr  = r_raddr;
    assign bus.bmem_rdata  = r_rdata;
    assign bus.proto_err   = r_err;
endmodule
